uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame-level receive controller between the `uart_rx` byte receiver and the command logic of the SoC. It consumes the receiver's byte stream over a valid/ready handshake and hunts for a sync byte. It then sequences the header, payload and checksum fields, forwards payload bytes downstream through a one-entry output register, and reports per-frame status. It also enforces an inter-byte timeout and keeps a saturating error counter.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYC`, default 32'd1_000_000: max idle clocks between bytes inside a frame; must be ≥2.
- `clk_i` input 1: clock.
- `rst_n_i` input 1: reset; one clock; synchronous, active-low.
- `rx_data_i` input 8: byte from `uart_rx`.
- `rx_data_vld_i` input 1: byte valid.
- `rx_data_rdy_o` output 1: byte accepted when `rx_data_vld_i & rx_data_rdy_o`.
- `pkt_data_o` output 8: payload byte.
- `pkt_vld_o` output 1: payload byte valid.
- `pkt_last_o` output 1: current payload byte is the last of the frame.
- `pkt_rdy_i` input 1: downstream accepts payload byte.
- `frame_cmd_o` output 8: CMD of the current/last frame; held until the next CMD is accepted.
- `frame_len_o` output 8: LEN of the current/last frame; held likewise.
- `frame_done_o` output 1: one-cycle pulse at frame end (good, bad checksum or timeout).
- `frame_ok_o` output 1: valid with `frame_done_o`; 1 = checksum matched.
- `frame_tmo_o` output 1: valid with `frame_done_o`; 1 = ended by timeout.
- `err_cnt_o` output 16: count of bad-checksum plus timeout frames; saturates at 16'hFFFF.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- CHK = XOR of CMD, LEN and all payload bytes.
- Accept = `rx_data_vld_i & rx_data_rdy_o`.
- States:
  - HUNT: `rx_data_rdy_o`=1; non-sync bytes are accepted and discarded. SYNC_BYTE → CMD.
  - CMD: `rdy`=1; on accept, store `frame_cmd_o`, set chk=byte → LEN.
  - LEN: `rdy`=1; on accept, store `frame_len_o`, load remaining count = byte, chk ^= byte. LEN=0 → CHK, else → DATA.
  - DATA: `rdy = ~pkt_vld_o | pkt_rdy_i`. On accept:
    - load `pkt_data_o`, set `pkt_vld_o`=1, chk ^= byte, decrement remaining.
    - `pkt_last_o`=1 when remaining was 1; then → CHK.
  - CHK: `rdy`=1; on accept, pulse `frame_done_o` with `frame_ok_o` = (byte == chk), `frame_tmo_o`=0 → HUNT.
- A SYNC_BYTE value in CMD/LEN/DATA/CHK position is treated as data; there is no mid-frame resync.
- Output register: `pkt_vld_o` clears on `pkt_rdy_i` unless reloaded in the same cycle. `pkt_data_o`/`pkt_last_o` hold while `pkt_vld_o & ~pkt_rdy_i`.
- Timeout counter (32 bit):
  - cleared in HUNT and on every accept.
  - frozen while `pkt_vld_o & ~pkt_rdy_i`; otherwise increments in CMD/LEN/DATA/CHK.
  - Reaching TIMEOUT_CYC−1 pulses `frame_done_o` with `frame_ok_o`=0, `frame_tmo_o`=1 → HUNT.
- Timeout and accept in the same cycle: accept wins, counter clears, no timeout.
- `err_cnt_o` increments by 1 on each `frame_done_o` with `frame_ok_o`=0, saturating.
- Payload already forwarded is not retracted on a bad checksum or timeout. Downstream discards using `frame_ok_o`.

## Timing
- Reset values:
  - state HUNT.
  - `rx_data_rdy_o`=1, `pkt_vld_o`=0, `pkt_last_o`=0, `pkt_data_o`=8'h00.
  - `frame_cmd_o`=`frame_len_o`=8'h00.
  - `frame_done_o`=`frame_ok_o`=`frame_tmo_o`=0, `err_cnt_o`=0.
  - timeout counter 0, chk 0.
- Reset asserted mid-frame aborts the frame with no `frame_done_o` pulse; any pending `pkt_vld_o` is dropped.
- `rx_data_rdy_o` is combinational from state, `pkt_vld_o` and `pkt_rdy_i`. All other outputs are registered.
- Latency:
  - payload byte accepted at edge N → `pkt_vld_o` high after edge N.
  - CHK accepted at edge N → `frame_done_o` high for the cycle after edge N; `err_cnt_o` updates at edge N+1.
- Full throughput: with `pkt_rdy_i`=1, one payload byte per clock.
- The CHK byte can be accepted while the last payload byte is still pending in the output register. `frame_done_o` may therefore precede consumption of the `pkt_last_o` byte.

## Test plan
- Good frame: A5, 01, 03, 10, 20, 30, 02 (01^03^10^20^30=02), `pkt_rdy_i`=1 → payload 10/20/30 with `pkt_last_o` on 30, `frame_done_o`=1, `frame_ok_o`=1, `frame_cmd_o`=01, `frame_len_o`=03, `err_cnt_o`=0.
- Bad checksum: same frame with CHK=03 → `frame_ok_o`=0, `frame_tmo_o`=0, `err_cnt_o`=1; next good frame → ok, count stays 1.
- Zero length plus garbage: 00, 7F, A5, 05, 00, 05 → the first two bytes are discarded; no `pkt_vld_o`; `frame_ok_o`=1, `frame_cmd_o`=05.
- Backpressure: good 3-byte frame with `pkt_rdy_i`=0 for 50 cycles and TIMEOUT_CYC=20 → `rx_data_rdy_o`=0 while full; no timeout; bytes delivered in order once `pkt_rdy_i`=1.
- Timeout: TIMEOUT_CYC=20, send A5, 01, 04, AA then stop → `frame_done_o` with `frame_tmo_o`=1, 20 cycles after AA is accepted; `err_cnt_o`=1; state HUNT. Repeat with a byte accepted exactly on the expiry cycle → no timeout.
- Reset mid-DATA after 2 of 4 payload bytes → all outputs return to their reset values; no `frame_done_o`; a following good frame parses correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level receive controller: sync hunt, header/payload/checksum
// sequencing, one-entry payload register, timeout and error count.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_data_vld_i,
  output logic        rx_data_rdy_o,
  output logic [7:0]  pkt_data_o,
  output logic        pkt_vld_o,
  output logic        pkt_last_o,
  input  logic        pkt_rdy_i,
  output logic [7:0]  frame_cmd_o,
  output logic [7:0]  frame_len_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        frame_tmo_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

  state_t      state_q;
  state_t      state_d;
  logic        acc;
  logic        stall;
  logic        tmo_hit;
  logic [31:0] cnt_q;
  logic [7:0]  chk_q;
  logic [7:0]  rem_q;

  assign stall = pkt_vld_o & ~pkt_rdy_i;
  assign acc   = rx_data_vld_i & rx_data_rdy_o;

  // a stalled output register freezes the timeout, so it cannot fire then
  assign tmo_hit = (state_q != S_HUNT) & ~acc & ~stall
                 & (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rx_data_rdy_o = 1'b1;
    if (state_q == S_DATA) begin
      rx_data_rdy_o = ~stall;
    end
    if (tmo_hit) begin
      state_d = S_HUNT;
    end else if (acc) begin
      unique case (state_q)
        S_HUNT: begin
          if (rx_data_i == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: state_d = S_LEN;
        S_LEN: begin
          state_d = (rx_data_i == 8'd0) ? S_CHK : S_DATA;
        end
        S_DATA: begin
          if (rem_q == 8'd1) state_d = S_CHK;
        end
        S_CHK: state_d = S_HUNT;
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      chk_q        <= '0;
      rem_q        <= '0;
      pkt_data_o   <= '0;
      pkt_vld_o    <= 1'b0;
      pkt_last_o   <= 1'b0;
      frame_cmd_o  <= '0;
      frame_len_o  <= '0;
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
      frame_tmo_o  <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
      frame_tmo_o  <= 1'b0;
      if (pkt_rdy_i) pkt_vld_o <= 1'b0;
      if (state_q == S_HUNT || acc) begin
        cnt_q <= '0;
      end else if (!stall) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (tmo_hit) begin
        frame_done_o <= 1'b1;
        frame_tmo_o  <= 1'b1;
      end
      if (acc) begin
        unique case (state_q)
          S_CMD: begin
            frame_cmd_o <= rx_data_i;
            chk_q       <= rx_data_i;
          end
          S_LEN: begin
            frame_len_o <= rx_data_i;
            rem_q       <= rx_data_i;
            chk_q       <= chk_q ^ rx_data_i;
          end
          S_DATA: begin
            pkt_data_o <= rx_data_i;
            pkt_vld_o  <= 1'b1;
            pkt_last_o <= (rem_q == 8'd1);
            chk_q      <= chk_q ^ rx_data_i;
            rem_q      <= rem_q - 8'd1;
          end
          S_CHK: begin
            frame_done_o <= 1'b1;
            frame_ok_o   <= (rx_data_i == chk_q);
          end
          default: ;
        endcase
      end
      // counts the frame reported in the previous cycle
      if (frame_done_o && !frame_ok_o && err_cnt_o != 16'hFFFF) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: payload and frame status
// expectations queued at stimulus time, compared at DUT output.
module tb_uart_rx_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [7:0]  rx_data_i;
  logic        rx_data_vld_i;
  logic        rx_data_rdy_o;
  logic [7:0]  pkt_data_o;
  logic        pkt_vld_o;
  logic        pkt_last_o;
  logic        pkt_rdy_i;
  logic [7:0]  frame_cmd_o;
  logic [7:0]  frame_len_o;
  logic        frame_done_o;
  logic        frame_ok_o;
  logic        frame_tmo_o;
  logic [15:0] err_cnt_o;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(32'd20)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .rx_data_i(rx_data_i),
    .rx_data_vld_i(rx_data_vld_i),
    .rx_data_rdy_o(rx_data_rdy_o),
    .pkt_data_o(pkt_data_o),
    .pkt_vld_o(pkt_vld_o),
    .pkt_last_o(pkt_last_o),
    .pkt_rdy_i(pkt_rdy_i),
    .frame_cmd_o(frame_cmd_o),
    .frame_len_o(frame_len_o),
    .frame_done_o(frame_done_o),
    .frame_ok_o(frame_ok_o),
    .frame_tmo_o(frame_tmo_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pkt_t;

  typedef struct {
    logic       ok;
    logic       tmo;
    logic [7:0] cmd;
    logic [7:0] len;
  } frm_t;

  pkt_t exp_pkt[$];
  frm_t exp_frm[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  always @(negedge clk_i) begin
    if (pkt_vld_o && pkt_rdy_i) begin
      if (exp_pkt.size() == 0) begin
        check("pkt_unexp", {31'd0, pkt_vld_o}, 32'd0);
      end else begin
        pkt_t e;
        e = exp_pkt.pop_front();
        check("pkt_data", {24'd0, pkt_data_o}, {24'd0, e.data});
        check("pkt_last", {31'd0, pkt_last_o}, {31'd0, e.last});
      end
    end
    if (frame_done_o) begin
      if (exp_frm.size() == 0) begin
        check("done_unexp", {31'd0, frame_done_o}, 32'd0);
      end else begin
        frm_t f;
        f = exp_frm.pop_front();
        check("frame_ok", {31'd0, frame_ok_o}, {31'd0, f.ok});
        check("frame_tmo", {31'd0, frame_tmo_o}, {31'd0, f.tmo});
        check("frame_cmd", {24'd0, frame_cmd_o}, {24'd0, f.cmd});
        check("frame_len", {24'd0, frame_len_o}, {24'd0, f.len});
        if (f.tmo) check("tmo_lat", cyc - acc_cyc, 32'd21);
      end
    end
  end

  // entered and left just after a rising edge
  task automatic send_byte(input logic [7:0] b);
    rx_data_i     = b;
    rx_data_vld_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (rx_data_rdy_o) begin
        acc_cyc = cyc;
        @(posedge clk_i);
        #1;
        rx_data_vld_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    check("send_tmo", {31'd0, rx_data_rdy_o}, 32'd1);
    rx_data_vld_i = 1'b0;
  endtask

  task automatic exp_frame(input logic ok, input logic tmo,
                           input logic [7:0] cmd, input logic [7:0] len);
    frm_t f;
    f.ok = ok; f.tmo = tmo; f.cmd = cmd; f.len = len;
    exp_frm.push_back(f);
  endtask

  task automatic send_payload(input logic [7:0] b, input logic last);
    pkt_t p;
    p.data = b; p.last = last;
    exp_pkt.push_back(p);
    send_byte(b);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (exp_pkt.size() == 0 && exp_frm.size() == 0) break;
    end
    if (i == 300) begin
      check("drain_pkt", exp_pkt.size(), 32'd0);
      check("drain_frm", exp_frm.size(), 32'd0);
    end
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic good_frame(input logic [7:0] chk);
    exp_frame(chk == 8'h02, 1'b0, 8'h01, 8'h03);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_payload(8'h10, 1'b0);
    send_payload(8'h20, 1'b0);
    send_payload(8'h30, 1'b1);
    send_byte(chk);
    drain();
  endtask

  task automatic check_reset_vals();
    check("rst_rdy", {31'd0, rx_data_rdy_o}, 32'd1);
    check("rst_pvld", {31'd0, pkt_vld_o}, 32'd0);
    check("rst_plast", {31'd0, pkt_last_o}, 32'd0);
    check("rst_pdata", {24'd0, pkt_data_o}, 32'd0);
    check("rst_cmd", {24'd0, frame_cmd_o}, 32'd0);
    check("rst_len", {24'd0, frame_len_o}, 32'd0);
    check("rst_done", {29'd0, frame_done_o, frame_ok_o, frame_tmo_o}, 32'd0);
    check("rst_err", {16'd0, err_cnt_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_i       = 1'b0;
    rx_data_i     = 8'h00;
    rx_data_vld_i = 1'b0;
    pkt_rdy_i     = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_vals();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    good_frame(8'h02);
    check("good_err", {16'd0, err_cnt_o}, 32'd0);

    good_frame(8'h03);
    check("bad_err", {16'd0, err_cnt_o}, 32'd1);
    good_frame(8'h02);
    check("good2_err", {16'd0, err_cnt_o}, 32'd1);

    exp_frame(1'b1, 1'b0, 8'h05, 8'h00);
    send_byte(8'h00);
    send_byte(8'h7F);
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h05);
    drain();
    check("zl_cmd", {24'd0, frame_cmd_o}, 32'h05);
    check("zl_len", {24'd0, frame_len_o}, 32'h00);

    pkt_rdy_i = 1'b0;
    fork
      begin
        repeat (50) @(posedge clk_i);
        #1;
        pkt_rdy_i = 1'b1;
      end
    join_none
    exp_frame(1'b1, 1'b0, 8'h01, 8'h03);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_payload(8'h10, 1'b0);
    @(negedge clk_i);
    check("bp_rdy", {31'd0, rx_data_rdy_o}, 32'd0);
    check("bp_pvld", {31'd0, pkt_vld_o}, 32'd1);
    @(posedge clk_i);
    #1;
    send_payload(8'h20, 1'b0);
    send_payload(8'h30, 1'b1);
    send_byte(8'h02);
    drain();
    check("bp_err", {16'd0, err_cnt_o}, 32'd1);

    exp_frame(1'b0, 1'b1, 8'h01, 8'h04);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    send_payload(8'hAA, 1'b0);
    drain();
    check("tmo_err", {16'd0, err_cnt_o}, 32'd2);
    check("tmo_hunt_cmd", {24'd0, frame_cmd_o}, 32'h01);

    exp_frame(1'b1, 1'b0, 8'h01, 8'h04);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    send_payload(8'hAA, 1'b0);
    repeat (19) @(posedge clk_i);
    #1;
    send_payload(8'hBB, 1'b0);
    send_payload(8'hCC, 1'b0);
    send_payload(8'hDD, 1'b1);
    send_byte(8'h05);
    drain();
    check("edge_err", {16'd0, err_cnt_o}, 32'd2);

    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h04);
    send_payload(8'h11, 1'b0);
    send_payload(8'h22, 1'b0);
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_reset_vals();
    @(posedge clk_i);
    #1;
    good_frame(8'h02);
    check("post_rst_err", {16'd0, err_cnt_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
